// File: rtl/register_down.sv
// Down-counting register with sticky borrow status.
// Start runs a decrement-by-Amount operation, one step per clock, and ends with a Done pulse.
module register_down #(
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic [WIDTH-1:0] Amount,
    input  logic             Clr_RS,
    output logic [WIDTH-1:0] R,
    output logic             RS,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state and datapath decode; a borrow step overrides a simultaneous Clr_RS.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        if (Clr_RS) begin
            rs_d = 1'b0;
        end else begin
            rs_d = rs_q;
        end
        case (state_q)
            IDLE: begin
                if (Load) begin
                    r_d = D;
                end else if (Start) begin
                    if (Amount == {WIDTH{1'b0}}) begin
                        state_d = FIN;
                    end else begin
                        cnt_d   = Amount;
                        state_d = DEC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DEC: begin
                r_d   = r_q - {{(WIDTH-1){1'b0}}, 1'b1};
                cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
                if (r_q == {WIDTH{1'b0}}) begin
                    rs_d = 1'b1;
                end else begin
                    rs_d = rs_d;
                end
                if (cnt_q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
                    state_d = FIN;
                end else begin
                    state_d = DEC;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == DEC);
        done_d = (state_d == FIN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            r_q     <= {WIDTH{1'b0}};
            cnt_q   <= {WIDTH{1'b0}};
            rs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign R    = r_q;
    assign RS   = rs_q;
    assign Busy = busy_q;
    assign Done = done_q;
    assign Zero = (r_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_register_down.sv
// Directed bench for register_down: per-cycle expected outputs go through a scoreboard queue.
module tb_register_down;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic       Load = 1'b0;
    logic [1:0] D = 2'd0;
    logic       Start = 1'b0;
    logic [1:0] Amount = 2'd0;
    logic       Clr_RS = 1'b0;
    logic [1:0] R;
    logic       RS;
    logic       Zero;
    logic       Busy;
    logic       Done;

    typedef struct packed {
        logic [1:0] r;
        logic       rs;
        logic       busy;
        logic       done;
        logic       zero;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    register_down #(.WIDTH(2)) dut (
        .CLK    (CLK),
        .Reset  (Reset),
        .Load   (Load),
        .D      (D),
        .Start  (Start),
        .Amount (Amount),
        .Clr_RS (Clr_RS),
        .R      (R),
        .RS     (RS),
        .Zero   (Zero),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic step(input string tag, input logic rst, input logic ld, input logic [1:0] d,
                        input logic st, input logic [1:0] amt, input logic clr,
                        input logic [1:0] er, input logic ers, input logic eb,
                        input logic edn, input logic ez);
        exp_t e;
        Reset  = rst;
        Load   = ld;
        D      = d;
        Start  = st;
        Amount = amt;
        Clr_RS = clr;
        exp_q.push_back('{r: er, rs: ers, busy: eb, done: edn, zero: ez});
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".R"},    R,            e.r);
        chk({tag, ".RS"},   {1'b0, RS},   {1'b0, e.rs});
        chk({tag, ".Busy"}, {1'b0, Busy}, {1'b0, e.busy});
        chk({tag, ".Done"}, {1'b0, Done}, {1'b0, e.done});
        chk({tag, ".Zero"}, {1'b0, Zero}, {1'b0, e.zero});
    endtask

    initial begin
        @(posedge CLK);
        #1;
        //      tag        rst ld d     st amt   clr  R     RS    Bsy   Dn    Z
        step("reset",     1, 1, 2'd3, 1, 2'd3, 0,   2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("ld_prio",   0, 1, 2'd2, 1, 2'd1, 0,   2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ld_idle",   0, 0, 2'd0, 0, 2'd0, 0,   2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ld3",       0, 1, 2'd3, 0, 2'd0, 0,   2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step("nb_start",  0, 0, 2'd0, 1, 2'd2, 0,   2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        step("nb_dec1",   0, 0, 2'd0, 0, 2'd0, 0,   2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step("nb_fin",    0, 0, 2'd0, 0, 2'd0, 0,   2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("nb_idle",   0, 0, 2'd0, 0, 2'd0, 0,   2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ld1",       0, 1, 2'd1, 0, 2'd0, 0,   2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("bw_start",  0, 0, 2'd0, 1, 2'd3, 0,   2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("bw_to0",    0, 0, 2'd0, 0, 2'd0, 0,   2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("bw_wrap",   0, 0, 2'd0, 0, 2'd0, 0,   2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        step("bw_fin",    0, 0, 2'd0, 0, 2'd0, 0,   2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        step("bw_idle",   0, 0, 2'd0, 0, 2'd0, 0,   2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step("st_start",  0, 0, 2'd0, 1, 2'd1, 0,   2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        step("st_fin",    0, 0, 2'd0, 0, 2'd0, 0,   2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        step("st_idle",   0, 0, 2'd0, 0, 2'd0, 0,   2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("clr_idle",  0, 0, 2'd0, 0, 2'd0, 1,   2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("cb_start",  0, 0, 2'd0, 1, 2'd2, 0,   2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("cb_to0",    0, 0, 2'd0, 0, 2'd0, 0,   2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("cb_wrap",   0, 0, 2'd0, 0, 2'd0, 1,   2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        step("cb_idle",   0, 0, 2'd0, 0, 2'd0, 0,   2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step("a0_start",  0, 0, 2'd0, 1, 2'd0, 0,   2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        step("a0_idle",   0, 0, 2'd0, 0, 2'd0, 0,   2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step("cd_start",  0, 0, 2'd0, 1, 2'd1, 0,   2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        step("cd_clr",    0, 0, 2'd0, 0, 2'd0, 1,   2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step("fin_start", 0, 0, 2'd0, 1, 2'd1, 0,   2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step("fin_after", 0, 0, 2'd0, 0, 2'd0, 0,   2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ig_start",  0, 0, 2'd0, 1, 2'd2, 0,   2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step("ig_ldst",   0, 1, 2'd0, 1, 2'd3, 0,   2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("ig_fin",    0, 0, 2'd0, 0, 2'd0, 0,   2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("ig_idle",   0, 0, 2'd0, 0, 2'd0, 0,   2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rm_ld",     0, 1, 2'd3, 0, 2'd0, 0,   2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rm_start",  0, 0, 2'd0, 1, 2'd3, 0,   2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        step("rm_dec1",   0, 0, 2'd0, 0, 2'd0, 0,   2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step("rm_reset",  1, 0, 2'd0, 0, 2'd0, 0,   2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rm_nodone", 0, 0, 2'd0, 0, 2'd0, 0,   2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rm_nodon2", 0, 0, 2'd0, 0, 2'd0, 0,   2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("mw_start",  0, 0, 2'd0, 1, 2'd3, 0,   2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("mw_wrap",   0, 0, 2'd0, 0, 2'd0, 0,   2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        step("mw_dec2",   0, 0, 2'd0, 0, 2'd0, 0,   2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        step("mw_fin",    0, 0, 2'd0, 0, 2'd0, 0,   2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        step("mw_idle",   0, 0, 2'd0, 0, 2'd0, 0,   2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_down.md
Name: register_down

Overview:
- Decrementing counterpart of the computer's up-counting R1/RS register pair.
- Holds a WIDTH-bit register R and a status register RS. It decrements R by a commanded amount, one step per clock.
- RS latches the borrow, i.e. wrap from 0 to all-ones. The status bit has the same meaning as the up-counter's carry-out status, in the opposite direction.
- Sits beside the up-counter register in the 2-bit computer datapath and is driven by the control sequencer through a Start/Done handshake.

Parameters:
- WIDTH, 2, width of R and of the Amount operand.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Load  input  1  load D into R (IDLE only).
- D  input  WIDTH  load value.
- Start  input  1  begin a decrement-by-Amount operation (IDLE only).
- Amount  input  WIDTH  number of single-step decrements to perform.
- Clr_RS  input  1  clear status register RS.
- R  output  WIDTH  register value.
- RS  output  1  sticky borrow status.
- Zero  output  1  combinational, high when R == 0.
- Busy  output  1  high while in DEC state.
- Done  output  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset is synchronous and active-high: Reset sampled high on a CLK rising edge forces R=0, RS=0, Done=0, state=IDLE and the internal step counter to 0. Reset overrides every other input in that cycle, including mid-operation; the aborted operation produces no Done.
- States: IDLE, DEC, FIN.
- IDLE, Load=1: R<=D next edge, no Done. Load has priority over Start when both are high; Start is then ignored, not queued.
- IDLE, Start=1, Load=0:
  - Amount==0: go to FIN directly; R unchanged.
  - Otherwise: capture Amount into the step counter and go to DEC.
  - Amount is sampled only in the Start cycle.
- DEC, each edge:
  - R<=R-1, modulo 2^WIDTH.
  - If R==0 before the step, RS<=1 (borrow).
  - Step counter decrements.
  - When the counter reaches 0 after this step, go to FIN.
  - Busy=1 throughout DEC.
  - Load and Start are ignored in DEC.
  - Latency: Amount cycles in DEC, then 1 cycle in FIN. Done is asserted Amount+1 cycles after the Start edge (1 cycle for Amount==0).
- FIN: Done=1 for exactly one cycle, Busy=0, then go to IDLE. Start in FIN is ignored. A new Start is accepted in the IDLE cycle following FIN.
- RS behaviour:
  - Sticky across operations.
  - Cleared only by Reset or Clr_RS.
  - Clr_RS is honoured in any state.
  - If Clr_RS coincides with a borrow step, the set wins (RS=1).
- Zero tracks R combinationally in all states, including during DEC.
- Arithmetic: all subtraction is WIDTH-bit unsigned wrap, with no saturation. Amount up to 2^WIDTH-1 is allowed; multiple wraps in one operation keep RS=1.

Test Plan:
- Reset then idle:
  - Apply Reset for 1 cycle with Start=1 and Load=1 also high -> R=0, RS=0, Busy=0, Done=0, Zero=1.
  - Reset asserted mid-DEC -> next edge returns R=0 and IDLE, and no Done pulse occurs.
- Load/priority:
  - Load=1, D=2'b10, Start=1 together -> R=2 and no operation starts (Busy stays 0).
- Decrement without borrow:
  - R=3, Start with Amount=2 -> R goes 2 then 1, Busy high for 2 cycles.
  - Done pulses on the 3rd edge after Start; RS=0.
- Borrow/wrap:
  - R=1, Amount=3 -> R goes 0, 3, 2; RS set on the 0->3 step; Done after 4 cycles.
  - RS stays 1 through a following Amount=1 operation.
- Clr_RS and Amount=0:
  - With RS=1, pulse Clr_RS in IDLE -> RS=0.
  - Clr_RS asserted in the same edge as a 0->3 borrow step -> RS=1.
  - Start with Amount=0 -> Done the next cycle, R unchanged, Busy never high.
